// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FSM encoding, byte counter sizing and default reset PC.
package ifu_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } ifu_state_e;

   localparam int INST_BYTES = 4;
   localparam int BYTE_CNT_W = 3;

   localparam logic [BYTE_CNT_W-1:0] LAST_CNT =
      BYTE_CNT_W'(INST_BYTES);

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory byte port, IF/ID handshake and redirect bundle.
// master = fetch unit side, slave = memory / pipeline side.
interface instruction_fetch_unit_if #(
   parameter int LEN = 32
);
   import ifu_pkg::*;

   logic [7:0]     mem_din;
   logic [LEN-1:0] mem_a;
   logic           mem_rd_en;
   logic           stall;
   logic           redirect_valid;
   logic [LEN-1:0] redirect_pc;
   logic           o_valid;
   logic [31:0]    o_inst;
   logic [LEN-1:0] o_c_pc;
   logic [LEN-1:0] o_n_pc;

   modport master (
      input  mem_din,
      input  stall,
      input  redirect_valid,
      input  redirect_pc,
      output mem_a,
      output mem_rd_en,
      output o_valid,
      output o_inst,
      output o_c_pc,
      output o_n_pc
   );

   modport slave (
      output mem_din,
      output stall,
      output redirect_valid,
      output redirect_pc,
      input  mem_a,
      input  mem_rd_en,
      input  o_valid,
      input  o_inst,
      input  o_c_pc,
      input  o_n_pc
   );

endinterface

// File: rtl/instruction_fetch_unit_fetch_byte_assembler.sv
// Little-endian byte insert buffer: count k (1..4) writes
// the byte returned for address pc+k-1 into lane k-1.
module fetch_byte_assembler
   import ifu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BYTE_CNT_W-1:0] byte_cnt,
   input  logic [7:0]            mem_din,
   input  logic                  clear,
   input  logic                  en,
   output logic [8*INST_BYTES-1:0] inst
);

   logic [1:0] lane;
   logic       wr;

   always_comb begin
      lane = 2'(byte_cnt - BYTE_CNT_W'(1));
      wr   = en && (byte_cnt != '0) &&
             (byte_cnt <= LAST_CNT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst <= '0;
      end else if (clear) begin
         inst <= '0;
      end else if (wr) begin
         inst[{lane, 3'b000} +: 8] <= mem_din;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns fetch PC, assembles 4 bytes per instruction.
// Optional perf counters: define IFU_PERF_CNT_EN.
module instruction_fetch_unit
   import ifu_pkg::*;
#(
   parameter int             LEN      = 32,
   parameter logic [LEN-1:0] RESET_PC = LEN'(DEF_RESET_PC)
) (
   input  logic clk,
   input  logic rst,
   input  logic rdy_in,
   instruction_fetch_unit_if.master bus
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0] o_fetch_cnt,
   output logic [31:0] o_flush_cnt
`endif
);

   ifu_state_e            state_q;
   ifu_state_e            state_d;
   logic [LEN-1:0]        pc_q;
   logic [LEN-1:0]        pc_d;
   logic [BYTE_CNT_W-1:0] cnt_q;
   logic [BYTE_CNT_W-1:0] cnt_d;
   logic                  clear;
   logic                  en;
   logic                  consume;
   logic [31:0]           inst_buf;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Redirect wins over stall and over HOLD consumption.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      clear   = 1'b0;
      en      = 1'b0;
      consume = 1'b0;
      if (rdy_in) begin
         if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc;
            cnt_d   = '0;
            state_d = FETCH;
            clear   = 1'b1;
         end else begin
            unique case (state_q)
               FETCH: begin
                  en = 1'b1;
                  if (cnt_q == LAST_CNT) begin
                     state_d = HOLD;
                  end else begin
                     cnt_d = cnt_q + BYTE_CNT_W'(1);
                  end
               end
               HOLD: begin
                  if (!bus.stall) begin
                     consume = 1'b1;
                     pc_d    = pc_q + LEN'(INST_BYTES);
                     cnt_d   = '0;
                     state_d = FETCH;
                  end
               end
               default: state_d = FETCH;
            endcase
         end
      end
   end

   fetch_byte_assembler u_asm (
      .clk      (clk),
      .rst      (rst),
      .byte_cnt (cnt_q),
      .mem_din  (bus.mem_din),
      .clear    (clear),
      .en       (en),
      .inst     (inst_buf)
   );

   // rst gates the request so nothing is issued while held in reset.
   always_comb begin
      bus.mem_a     = pc_q + LEN'(cnt_q);
      bus.mem_rd_en = rst && rdy_in &&
                      (state_q == FETCH) &&
                      (cnt_q < LAST_CNT);
      bus.o_valid   = (state_q == HOLD);
      bus.o_inst    = inst_buf;
      bus.o_c_pc    = pc_q;
      bus.o_n_pc    = pc_q + LEN'(INST_BYTES);
   end

`ifdef IFU_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_fetch_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         if (consume) begin
            o_fetch_cnt <= o_fetch_cnt + 32'd1;
         end
         if (rdy_in && bus.redirect_valid) begin
            o_flush_cnt <= o_flush_cnt + 32'd1;
         end
      end
   end
`else
   logic unused_consume;
   assign unused_consume = consume;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed table-driven bench for instruction_fetch_unit.
// Vectors hold per-cycle inputs and the outputs seen that cycle.
module tb_instruction_fetch_unit;
   import ifu_pkg::*;

   typedef struct {
      logic        rdy;
      logic        stall;
      logic        rv;
      logic [31:0] rpc;
      logic        ev;
      logic        er;
      logic [31:0] ea;
      logic [31:0] ei;
      logic [31:0] epc;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rdy_in = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] mem [512];
   vec_t vq [$];

   instruction_fetch_unit_if #(.LEN(32)) bus();

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] flush_cnt;
`endif

   instruction_fetch_unit #(
      .LEN      (32),
      .RESET_PC (32'h0)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .rdy_in (rdy_in),
      .bus    (bus)
`ifdef IFU_PERF_CNT_EN
      ,
      .o_fetch_cnt (fetch_cnt),
      .o_flush_cnt (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Byte memory: data for an address appears one cycle later.
   always @(posedge clk or negedge rst) begin
      if (!rst) bus.mem_din <= 8'h00;
      else if (bus.mem_rd_en)
         bus.mem_din <= mem[bus.mem_a[8:0]];
   end

   task automatic chk(input string nm, input int k,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d got %h want %h",
                  nm, k, act, exp);
      end
   endtask

   task automatic add(input logic rdy, input logic st,
                      input logic rv, input logic [31:0] rpc,
                      input logic ev, input logic er,
                      input logic [31:0] ea,
                      input logic [31:0] ei,
                      input logic [31:0] epc);
      vec_t v;
      v.rdy = rdy; v.stall = st; v.rv = rv; v.rpc = rpc;
      v.ev = ev; v.er = er; v.ea = ea;
      v.ei = ei; v.epc = epc;
      vq.push_back(v);
   endtask

   task automatic f(input logic [31:0] a);
      add(1, 0, 0, 0, 0, 1, a, 0, 0);
   endtask

   task automatic fr(input logic [31:0] a,
                     input logic [31:0] rpc);
      add(1, 0, 1, rpc, 0, 1, a, 0, 0);
   endtask

   task automatic f4();
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic idle();
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic h(input logic st, input logic rv,
                    input logic [31:0] rpc,
                    input logic [31:0] ei,
                    input logic [31:0] epc);
      add(1, st, rv, rpc, 1, 0, 0, ei, epc);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      mem[0] = 8'h13; mem[1] = 8'h05;
      mem[2] = 8'hA0; mem[3] = 8'h00;
      mem[4] = 8'h93; mem[5] = 8'h05;
      mem[6] = 8'h10; mem[7] = 8'h00;
      mem[8] = 8'h13; mem[9] = 8'h06;
      mem[10] = 8'h20; mem[11] = 8'h00;
      mem[64] = 8'h78; mem[65] = 8'h56;
      mem[66] = 8'h34; mem[67] = 8'h12;
      mem[256] = 8'hEF; mem[257] = 8'hBE;
      mem[258] = 8'hAD; mem[259] = 8'hDE;
      mem[510] = 8'hAA; mem[511] = 8'hBB;

      // nominal fetch, then 3-cycle stall in HOLD
      f(0); f(1); f(2); f(3); f4();
      h(1, 0, 0, 32'h00A00513, 0);
      h(1, 0, 0, 32'h00A00513, 0);
      h(1, 0, 0, 32'h00A00513, 0);
      h(0, 0, 0, 32'h00A00513, 0);
      // rdy_in low for 4 cycles at byte_cnt=1
      f(4); idle(); idle(); idle(); idle();
      f(5); f(6); f(7); f4();
      h(0, 0, 0, 32'h00100593, 4);
      // redirect beats stall in HOLD
      f(8); f(9); f(10); f(11); f4();
      h(1, 1, 32'h40, 32'h00200613, 8);
      // redirect mid-fetch at byte_cnt=2
      f(32'h40); f(32'h41); fr(32'h42, 32'h100);
      f(32'h100); f(32'h101); f(32'h102); f(32'h103);
      f4();
      h(0, 1, 32'hFFFF_FFFE, 32'hDEADBEEF, 32'h100);
      // address wrap
      f(32'hFFFF_FFFE); f(32'hFFFF_FFFF); f(0); f(1);
      f4();
      h(0, 0, 0, 32'h0513BBAA, 32'hFFFF_FFFE);
      // unaligned pc after wrap
      f(2); f(3); f(4); f(5); f4();
      h(1, 0, 0, 32'h059300A0, 2);

      rdy_in = 1'b1;
      bus.stall = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_valid", -1, 32'(bus.o_valid), 0);
      chk("rst_inst", -1, bus.o_inst, 0);
      chk("rst_c_pc", -1, bus.o_c_pc, 0);
      chk("rst_n_pc", -1, bus.o_n_pc, 4);
      chk("rst_rd_en", -1, 32'(bus.mem_rd_en), 0);
      chk("rst_mem_a", -1, bus.mem_a, 0);
      rst = 1'b1;

      foreach (vq[k]) begin
         rdy_in = vq[k].rdy;
         bus.stall = vq[k].stall;
         bus.redirect_valid = vq[k].rv;
         bus.redirect_pc = vq[k].rpc;
         #1;
         chk("o_valid", k, 32'(bus.o_valid),
             32'(vq[k].ev));
         chk("mem_rd_en", k, 32'(bus.mem_rd_en),
             32'(vq[k].er));
         if (vq[k].er) chk("mem_a", k, bus.mem_a, vq[k].ea);
         if (vq[k].ev) begin
            chk("o_inst", k, bus.o_inst, vq[k].ei);
            chk("o_c_pc", k, bus.o_c_pc, vq[k].epc);
            chk("o_n_pc", k, bus.o_n_pc,
                vq[k].epc + 32'd4);
         end
         @(negedge clk);
      end

      chk("hold_valid", 100, 32'(bus.o_valid), 1);
`ifdef IFU_PERF_CNT_EN
      chk("fetch_cnt", 100, fetch_cnt, 3);
      chk("flush_cnt", 100, flush_cnt, 3);
`endif

      // async reset pulse mid-HOLD, off the clock edge
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("arst_valid", 200, 32'(bus.o_valid), 0);
      chk("arst_c_pc", 200, bus.o_c_pc, 0);
      chk("arst_n_pc", 200, bus.o_n_pc, 4);
      chk("arst_inst", 200, bus.o_inst, 0);
`ifdef IFU_PERF_CNT_EN
      chk("arst_fetch_cnt", 200, fetch_cnt, 0);
      chk("arst_flush_cnt", 200, flush_cnt, 0);
`endif
      @(negedge clk);
      rst = 1'b1;
      bus.stall = 1'b1;
      n = 0;
      while (!bus.o_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 201, 32'(n), 5);
      chk("lat_valid", 201, 32'(bus.o_valid), 1);
      chk("lat_inst", 201, bus.o_inst, 32'h00A00513);
      chk("lat_c_pc", 201, bus.o_c_pc, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
